// File: rtl/regfile_pkg.sv
// Shared widths, special register indices and data typedefs for the
// scoreboarded register file.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_LINK_REG = 31;
  localparam int ZERO_REG     = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write tracker: one pending bit per architectural
// register plus an incrementally maintained count of set bits.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LINK_REG = DEF_LINK_REG
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_addr,
  input  logic                   link_clr_en,
  output logic [2**ADDR_W-1:0]   pend,
  output logic [ADDR_W:0]        pend_cnt
);

  localparam int                DEPTH  = 2**ADDR_W;
  localparam int                CW     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] pend_next;
  logic             set_ok;
  logic             inc;
  logic             dec_w;
  logic             dec_l;

  // A new issue overrides a same-edge clear: the newest producer owns the register.
  always_comb begin
    set_ok    = set_en && (set_addr != ZERO_A);
    pend_next = pend;
    if (clr_en)      pend_next[clr_addr] = 1'b0;
    if (link_clr_en) pend_next[LINK_A]   = 1'b0;
    if (set_ok)      pend_next[set_addr] = 1'b1;
    pend_next[0] = 1'b0;

    inc   = set_ok && !pend[set_addr];
    dec_w = clr_en && pend[clr_addr] && !(set_ok && (set_addr == clr_addr));
    dec_l = link_clr_en && pend[LINK_A] && !(set_ok && (set_addr == LINK_A))
            && !(clr_en && (clr_addr == LINK_A));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_next;
      pend_cnt <= pend_cnt + CW'(inc) - CW'(dec_w) - CW'(dec_l);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with link-register port and pending-write
// scoreboard. Define REGFILE_BYPASS_EN for write-first read forwarding.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LINK_REG = DEF_LINK_REG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] b_data,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              reg_wr,
  input  logic              ra_wr,
  input  logic [DATA_W-1:0] ra_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              a_busy,
  output logic              b_busy,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int                DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              gen_wr;
  logic              link_wr;

  // The general port wins a same-edge collision on the link register.
  assign gen_wr  = reg_wr && (w_addr != ZERO_A);
  assign link_wr = ra_wr && !(gen_wr && (w_addr == LINK_A));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (gen_wr)  regs[w_addr] <= w_data;
      if (link_wr) regs[LINK_A] <= ra_data;
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .LINK_REG (LINK_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en      (iss_valid),
    .set_addr    (iss_addr),
    .clr_en      (gen_wr),
    .clr_addr    (w_addr),
    .link_clr_en (link_wr),
    .pend        (pend),
    .pend_cnt    (pend_cnt)
  );

  // Outputs are forced quiet while reset is held so forwarding cannot leak data.
  always_comb begin
    a_data = '0;
    b_data = '0;
    a_busy = 1'b0;
    b_busy = 1'b0;
    if (rst) begin
      if (a_addr != ZERO_A) begin
        a_data = regs[a_addr];
        a_busy = pend[a_addr];
      end
      if (b_addr != ZERO_A) begin
        b_data = regs[b_addr];
        b_busy = pend[b_addr];
      end
`ifdef REGFILE_BYPASS_EN
      if (link_wr && (a_addr == LINK_A)) begin
        a_data = ra_data;
        a_busy = 1'b0;
      end
      if (gen_wr && (a_addr == w_addr)) begin
        a_data = w_data;
        a_busy = 1'b0;
      end
      if (link_wr && (b_addr == LINK_A)) begin
        b_data = ra_data;
        b_busy = 1'b0;
      end
      if (gen_wr && (b_addr == w_addr)) begin
        b_data = w_data;
        b_busy = 1'b0;
      end
`endif
    end
  end

endmodule
